// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline control unit: FSM states, forward-select codes
// and the drain length used between halt acceptance and the halted state.
// Pure declarations; no logic, no latency, no flow control.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_HALTED = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_t;

    // Non-frozen cycles spent in DRAIN while the halt walks EX -> MEM -> WB.
    localparam logic [1:0] DRAIN_CYC = 2'd2;

endpackage

// File: rtl/pipe_fwd_sel.sv
// Forward-select for one EX operand: picks EX/MEM, then MEM/WB, else the regfile.
// Latency: purely combinational.
// Backpressure: none; the result is only meaningful while EX holds a valid op.
//
// Ports: ex_rs (operand register in EX), mem_rd/mem_wr_en and wb_rd/wb_wr_en
// (older writers), fwd (FWD_RF / FWD_MEM / FWD_WB).
module pipe_fwd_sel
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_wr_en,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_wr_en,
    output logic [1:0]        fwd
);

    // x0 is hardwired to zero, so a write to it is never a forwarding source.
    // The younger producer (EX/MEM) wins over MEM/WB.
    always_comb begin
        fwd = FWD_RF;
        if (mem_wr_en && (mem_rd != '0) && (mem_rd == ex_rs)) begin
            fwd = FWD_MEM;
        end else if (wb_wr_en && (wb_rd != '0) && (wb_rd == ex_rs)) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control for the 5-stage core: enables, flushes, forwarding, redirect, halt drain.
// Latency: controls are combinational from inputs + state; FSM/counters update on posedge clk.
// Backpressure: ext_stall freezes every stage register and all internal state.
//
// Ports: hazard/branch/halt info from ID, EX, MEM, WB in; en_* / flush_* / fwd_* /
// redirect / halt / state out; perf_* counters (live only with PIPE_PERF_EN defined,
// otherwise tied to zero with no counter flops).
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int PC_W     = 32,
    parameter int REG_AW   = 5,
    parameter int LU_STALL = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ext_stall,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic              id_halt,
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_wr_en,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_wr_en,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_wr_en,
    input  logic              br_resolve,
    input  logic              br_taken,
    input  logic              br_predicted,
    input  logic [PC_W-1:0]   br_target,
    input  logic [PC_W-1:0]   br_pc_seq,
    output logic              en_pc,
    output logic              en_if_id,
    output logic              en_id_ex,
    output logic              en_ex_mem,
    output logic              en_mem_wb,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              redirect,
    output logic [PC_W-1:0]   redirect_pc,
    output logic              halt,
    output logic [1:0]        state,
    output logic [31:0]       perf_cyc,
    output logic [31:0]       perf_stall,
    output logic [31:0]       perf_flush
);

    // The detection cycle is itself a stall cycle, so the counter only covers the rest.
    localparam logic [1:0] LU_LOAD = 2'(LU_STALL - 1);

    state_t     state_q, state_d;
    logic [1:0] stall_cnt_q, stall_cnt_d;
    logic [1:0] drain_cnt_q, drain_cnt_d;
    logic       mispredict;
    logic       lu_hazard;
    logic       mp_evt;

    pipe_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .ex_rs     (ex_rs1),
        .mem_rd    (mem_rd),
        .mem_wr_en (mem_wr_en),
        .wb_rd     (wb_rd),
        .wb_wr_en  (wb_wr_en),
        .fwd       (fwd_a)
    );

    pipe_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .ex_rs     (ex_rs2),
        .mem_rd    (mem_rd),
        .mem_wr_en (mem_wr_en),
        .wb_rd     (wb_rd),
        .wb_wr_en  (wb_wr_en),
        .fwd       (fwd_b)
    );

    assign mispredict = br_resolve && (br_taken != br_predicted);

    assign lu_hazard = ex_is_load && ex_wr_en && (ex_rd != '0) && id_valid &&
                       ((id_rs1_used && (id_rs1 == ex_rd)) ||
                        (id_rs2_used && (id_rs2 == ex_rd)));

    always_comb begin
        en_pc       = 1'b1;
        en_if_id    = 1'b1;
        en_id_ex    = 1'b1;
        en_ex_mem   = 1'b1;
        en_mem_wb   = 1'b1;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        halt        = 1'b0;
        mp_evt      = 1'b0;
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        drain_cnt_d = drain_cnt_q;

        case (state_q)
            ST_RUN: begin
                if (ext_stall) begin
                    {en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb} = '0;
                end else if (mispredict) begin
                    redirect    = 1'b1;
                    redirect_pc = br_taken ? br_target : br_pc_seq;
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                    stall_cnt_d = '0;
                    mp_evt      = 1'b1;
                end else if (lu_hazard || (stall_cnt_q != '0)) begin
                    // Hold the consumer in ID and inject a bubble into EX.
                    en_pc       = 1'b0;
                    en_if_id    = 1'b0;
                    flush_id_ex = 1'b1;
                    stall_cnt_d = lu_hazard ? LU_LOAD : (stall_cnt_q - 2'd1);
                end else if (id_halt && id_valid) begin
                    // The halt itself moves on into EX this cycle.
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DRAIN_CYC;
                end
            end

            ST_DRAIN: begin
                if (ext_stall) begin
                    {en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb} = '0;
                end else if (mispredict) begin
                    // An older branch was wrong: the halt is on the wrong path.
                    redirect    = 1'b1;
                    redirect_pc = br_taken ? br_target : br_pc_seq;
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                    mp_evt      = 1'b1;
                    state_d     = ST_RUN;
                    drain_cnt_d = '0;
                end else begin
                    en_pc       = 1'b0;
                    en_if_id    = 1'b0;
                    flush_if_id = 1'b1;
                    // Counter reaching zero means the halt is leaving MEM/WB.
                    if (drain_cnt_q <= 2'd1) begin
                        state_d     = ST_HALTED;
                        drain_cnt_d = '0;
                    end else begin
                        drain_cnt_d = drain_cnt_q - 2'd1;
                    end
                end
            end

            ST_HALTED: begin
                halt = 1'b1;
                {en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb} = '0;
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    assign state = state_q;

`ifdef PIPE_PERF_EN
    logic [31:0] cyc_q, stall_q, flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q   <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (state_q != ST_HALTED)             cyc_q   <= cyc_q + 32'd1;
            if ((state_q == ST_RUN) && !en_pc)    stall_q <= stall_q + 32'd1;
            if (mp_evt)                           flush_q <= flush_q + 32'd1;
        end
    end

    assign perf_cyc   = cyc_q;
    assign perf_stall = stall_q;
    assign perf_flush = flush_q;
`else
    logic unused_perf;
    assign unused_perf = mp_evt;
    assign perf_cyc    = '0;
    assign perf_stall  = '0;
    assign perf_flush  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with an expected-output queue checked once per cycle.
// Latency: inputs change 1 time unit after posedge, outputs sampled at negedge.
// Backpressure: ext_stall windows are exercised explicitly.
module tb_pipe_ctrl;

    localparam int PC_W = 32;
    localparam int AW   = 5;
    localparam int LU   = 2;

    localparam logic [4:0] EN_ALL   = 5'b11111;
    localparam logic [4:0] EN_NONE  = 5'b00000;
    localparam logic [4:0] EN_STALL = 5'b00111;
    localparam logic [1:0] FL_NONE  = 2'b00;
    localparam logic [1:0] FL_IDEX  = 2'b01;
    localparam logic [1:0] FL_IFID  = 2'b10;
    localparam logic [1:0] FL_BOTH  = 2'b11;

    typedef logic [46:0] obs_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            ext_stall, id_valid, id_rs1_used, id_rs2_used, id_halt;
    logic [AW-1:0]   id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic            ex_wr_en, ex_is_load, mem_wr_en, wb_wr_en;
    logic            br_resolve, br_taken, br_predicted;
    logic [PC_W-1:0] br_target, br_pc_seq;
    logic            en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
    logic            flush_if_id, flush_id_ex, redirect, halt;
    logic [1:0]      fwd_a, fwd_b, state;
    logic [PC_W-1:0] redirect_pc;
    logic [31:0]     perf_cyc, perf_stall, perf_flush;

    int    tests = 0;
    int    fails = 0;
    obs_t  exp_q[$];
    string tag_q[$];

    always #5 clk = ~clk;

    pipe_ctrl #(.PC_W(PC_W), .REG_AW(AW), .LU_STALL(LU)) dut (
        .clk(clk), .rst_n(rst_n), .ext_stall(ext_stall),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_halt(id_halt),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
        .mem_rd(mem_rd), .mem_wr_en(mem_wr_en), .wb_rd(wb_rd), .wb_wr_en(wb_wr_en),
        .br_resolve(br_resolve), .br_taken(br_taken), .br_predicted(br_predicted),
        .br_target(br_target), .br_pc_seq(br_pc_seq),
        .en_pc(en_pc), .en_if_id(en_if_id), .en_id_ex(en_id_ex),
        .en_ex_mem(en_ex_mem), .en_mem_wb(en_mem_wb),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .redirect(redirect), .redirect_pc(redirect_pc),
        .halt(halt), .state(state),
        .perf_cyc(perf_cyc), .perf_stall(perf_stall), .perf_flush(perf_flush)
    );

    task automatic idle();
        ext_stall = 0; id_valid = 0; id_rs1 = 0; id_rs2 = 0;
        id_rs1_used = 0; id_rs2_used = 0; id_halt = 0;
        ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_wr_en = 0; ex_is_load = 0;
        mem_rd = 0; mem_wr_en = 0; wb_rd = 0; wb_wr_en = 0;
        br_resolve = 0; br_taken = 0; br_predicted = 0;
        br_target = 32'h0; br_pc_seq = 32'h0;
    endtask

    task automatic load_use_rs1();
        ex_rd = 5; ex_wr_en = 1; ex_is_load = 1;
        id_valid = 1; id_rs1 = 5; id_rs1_used = 1;
    endtask

    task automatic mispredict_taken(input logic [PC_W-1:0] tgt);
        br_resolve = 1; br_taken = 1; br_predicted = 0;
        br_target = tgt; br_pc_seq = 32'h44;
    endtask

    // Queue the expectation for this cycle, sample at negedge, compare, advance.
    task automatic chk(input string tag, input logic [4:0] en, input logic [1:0] fl,
                       input logic [1:0] fa, input logic [1:0] fb, input logic rd,
                       input logic [31:0] rpc, input logic h, input logic [1:0] st);
        obs_t  got, e;
        string t;
        exp_q.push_back({en, fl, fa, fb, rd, rpc, h, st});
        tag_q.push_back(tag);
        @(negedge clk);
        got = {en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb, flush_if_id, flush_id_ex,
               fwd_a, fwd_b, redirect, redirect_pc, halt, state};
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        tests++;
        assert (got === e) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", t, got, e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [95:0] perf_exp, perf_got;
        idle();
        rst_n = 0;
        #3;
        chk("reset", EN_ALL, FL_NONE, 2'b00, 2'b00, 0, 0, 0, 2'b00);
        rst_n = 1;

        // Forwarding
        idle(); mem_rd = 7; mem_wr_en = 1; wb_rd = 7; wb_wr_en = 1; ex_rs2 = 7;
        chk("fwd_b_mem_prio", EN_ALL, FL_NONE, 2'b00, 2'b01, 0, 0, 0, 2'b00);
        mem_rd = 0;
        chk("fwd_b_wb", EN_ALL, FL_NONE, 2'b00, 2'b10, 0, 0, 0, 2'b00);
        wb_rd = 0; ex_rs2 = 0;
        chk("fwd_b_x0", EN_ALL, FL_NONE, 2'b00, 2'b00, 0, 0, 0, 2'b00);
        idle(); ex_rs1 = 3; mem_rd = 3; wb_rd = 3; wb_wr_en = 1;
        chk("fwd_a_wb_memoff", EN_ALL, FL_NONE, 2'b10, 2'b00, 0, 0, 0, 2'b00);
        mem_wr_en = 1;
        chk("fwd_a_mem", EN_ALL, FL_NONE, 2'b01, 2'b00, 0, 0, 0, 2'b00);

        // Load-use on rs1: LU stall cycles, then the consumer proceeds
        idle(); load_use_rs1();
        chk("lu_detect", EN_STALL, FL_IDEX, 2'b00, 2'b00, 0, 0, 0, 2'b00);
        idle(); mem_rd = 5; mem_wr_en = 1; id_valid = 1; id_rs1 = 5; id_rs1_used = 1;
        chk("lu_hold", EN_STALL, FL_IDEX, 2'b00, 2'b00, 0, 0, 0, 2'b00);
        idle(); wb_rd = 5; wb_wr_en = 1; ex_rs1 = 5;
        chk("lu_release_fwd_wb", EN_ALL, FL_NONE, 2'b10, 2'b00, 0, 0, 0, 2'b00);

        // Non-hazards and rs2 hazard
        idle(); ex_rd = 5; ex_wr_en = 1; ex_is_load = 1; id_valid = 1; id_rs2 = 5;
        chk("lu_rs2_unused", EN_ALL, FL_NONE, 2'b00, 2'b00, 0, 0, 0, 2'b00);
        idle(); ex_wr_en = 1; ex_is_load = 1; id_valid = 1; id_rs1_used = 1;
        chk("lu_rd_x0", EN_ALL, FL_NONE, 2'b00, 2'b00, 0, 0, 0, 2'b00);
        idle(); ex_rd = 9; ex_wr_en = 1; ex_is_load = 1; id_valid = 1; id_rs2 = 9; id_rs2_used = 1;
        chk("lu_rs2_detect", EN_STALL, FL_IDEX, 2'b00, 2'b00, 0, 0, 0, 2'b00);
        idle();
        chk("lu_rs2_hold", EN_STALL, FL_IDEX, 2'b00, 2'b00, 0, 0, 0, 2'b00);
        chk("lu_rs2_done", EN_ALL, FL_NONE, 2'b00, 2'b00, 0, 0, 0, 2'b00);

        // Branch outcomes
        idle(); mispredict_taken(32'h100);
        chk("mp_taken", EN_ALL, FL_BOTH, 2'b00, 2'b00, 1, 32'h100, 0, 2'b00);
        idle();
        chk("mp_one_cycle", EN_ALL, FL_NONE, 2'b00, 2'b00, 0, 0, 0, 2'b00);
        br_resolve = 1; br_taken = 0; br_predicted = 1; br_target = 32'h100; br_pc_seq = 32'h44;
        chk("mp_not_taken", EN_ALL, FL_BOTH, 2'b00, 2'b00, 1, 32'h44, 0, 2'b00);
        br_taken = 1;
        chk("br_correct", EN_ALL, FL_NONE, 2'b00, 2'b00, 0, 0, 0, 2'b00);
        br_resolve = 0; br_predicted = 0;
        chk("br_unresolved", EN_ALL, FL_NONE, 2'b00, 2'b00, 0, 0, 0, 2'b00);

        // Priorities
        idle(); load_use_rs1(); mispredict_taken(32'h180);
        chk("mp_over_lu", EN_ALL, FL_BOTH, 2'b00, 2'b00, 1, 32'h180, 0, 2'b00);
        idle();
        chk("mp_over_lu_nostall", EN_ALL, FL_NONE, 2'b00, 2'b00, 0, 0, 0, 2'b00);
        load_use_rs1();
        chk("lu_then_mp_detect", EN_STALL, FL_IDEX, 2'b00, 2'b00, 0, 0, 0, 2'b00);
        idle(); mispredict_taken(32'h1c0);
        chk("mp_cancels_lu", EN_ALL, FL_BOTH, 2'b00, 2'b00, 1, 32'h1c0, 0, 2'b00);
        idle();
        chk("lu_cancelled", EN_ALL, FL_NONE, 2'b00, 2'b00, 0, 0, 0, 2'b00);
        mispredict_taken(32'h200); ext_stall = 1;
        chk("ext_over_mp", EN_NONE, FL_NONE, 2'b00, 2'b00, 0, 0, 0, 2'b00);

        // ext_stall freezes the load-use counter
        idle(); load_use_rs1();
        chk("lu_ext_detect", EN_STALL, FL_IDEX, 2'b00, 2'b00, 0, 0, 0, 2'b00);
        for (int i = 0; i < 4; i++) begin
            idle(); ext_stall = 1;
            chk("lu_ext_frozen", EN_NONE, FL_NONE, 2'b00, 2'b00, 0, 0, 0, 2'b00);
        end
        idle();
        chk("lu_ext_resume", EN_STALL, FL_IDEX, 2'b00, 2'b00, 0, 0, 0, 2'b00);
        chk("lu_ext_done", EN_ALL, FL_NONE, 2'b00, 2'b00, 0, 0, 0, 2'b00);

        // Halt entry blocked by mispredict / load-use / ext_stall
        idle(); id_valid = 1; id_halt = 1; mispredict_taken(32'h240);
        chk("halt_vs_mp", EN_ALL, FL_BOTH, 2'b00, 2'b00, 1, 32'h240, 0, 2'b00);
        idle();
        chk("halt_vs_mp_run", EN_ALL, FL_NONE, 2'b00, 2'b00, 0, 0, 0, 2'b00);
        load_use_rs1(); id_halt = 1;
        chk("halt_vs_lu", EN_STALL, FL_IDEX, 2'b00, 2'b00, 0, 0, 0, 2'b00);
        idle();
        chk("halt_vs_lu_hold", EN_STALL, FL_IDEX, 2'b00, 2'b00, 0, 0, 0, 2'b00);
        id_valid = 1; id_halt = 1; ext_stall = 1;
        chk("halt_vs_ext", EN_NONE, FL_NONE, 2'b00, 2'b00, 0, 0, 0, 2'b00);

        // Halt drain with one frozen cycle inside DRAIN
        ext_stall = 0;
        chk("halt_accept", EN_ALL, FL_NONE, 2'b00, 2'b00, 0, 0, 0, 2'b00);
        idle();
        chk("drain_1", EN_STALL, FL_IFID, 2'b00, 2'b00, 0, 0, 0, 2'b01);
        ext_stall = 1;
        chk("drain_frozen", EN_NONE, FL_NONE, 2'b00, 2'b00, 0, 0, 0, 2'b01);
        ext_stall = 0;
        chk("drain_2", EN_STALL, FL_IFID, 2'b00, 2'b00, 0, 0, 0, 2'b01);
        chk("halted", EN_NONE, FL_NONE, 2'b00, 2'b00, 0, 0, 1, 2'b11);
        id_valid = 1; id_halt = 1; mispredict_taken(32'h300);
        chk("halted_holds", EN_NONE, FL_NONE, 2'b00, 2'b00, 0, 0, 1, 2'b11);
        idle(); rst_n = 0;
        chk("reset_from_halted", EN_ALL, FL_NONE, 2'b00, 2'b00, 0, 0, 0, 2'b00);
        rst_n = 1;

        // Plain drain timing: halt exactly 3 cycles after acceptance
        id_valid = 1; id_halt = 1;
        chk("halt2_accept", EN_ALL, FL_NONE, 2'b00, 2'b00, 0, 0, 0, 2'b00);
        idle();
        chk("halt2_c1", EN_STALL, FL_IFID, 2'b00, 2'b00, 0, 0, 0, 2'b01);
        chk("halt2_c2", EN_STALL, FL_IFID, 2'b00, 2'b00, 0, 0, 0, 2'b01);
        chk("halt2_c3", EN_NONE, FL_NONE, 2'b00, 2'b00, 0, 0, 1, 2'b11);
        rst_n = 0;
        chk("reset2", EN_ALL, FL_NONE, 2'b00, 2'b00, 0, 0, 0, 2'b00);
        rst_n = 1;

        // Mispredict during DRAIN returns to RUN
        id_valid = 1; id_halt = 1;
        chk("halt3_accept", EN_ALL, FL_NONE, 2'b00, 2'b00, 0, 0, 0, 2'b00);
        idle(); mispredict_taken(32'h200);
        chk("drain_mp", EN_ALL, FL_BOTH, 2'b00, 2'b00, 1, 32'h200, 0, 2'b01);
        idle();
        chk("drain_mp_run", EN_ALL, FL_NONE, 2'b00, 2'b00, 0, 0, 0, 2'b00);
        chk("drain_mp_no_halt", EN_ALL, FL_NONE, 2'b00, 2'b00, 0, 0, 0, 2'b00);

        // Reset mid-DRAIN
        id_valid = 1; id_halt = 1;
        chk("halt4_accept", EN_ALL, FL_NONE, 2'b00, 2'b00, 0, 0, 0, 2'b00);
        idle();
        chk("halt4_drain", EN_STALL, FL_IFID, 2'b00, 2'b00, 0, 0, 0, 2'b01);
        rst_n = 0;
        chk("reset_mid_drain", EN_ALL, FL_NONE, 2'b00, 2'b00, 0, 0, 0, 2'b00);
        rst_n = 1;

        // Perf counters from a clean reset: 5 cycles, 1 mispredict, LU stall cycles
        chk("perf_idle0", EN_ALL, FL_NONE, 2'b00, 2'b00, 0, 0, 0, 2'b00);
        chk("perf_idle1", EN_ALL, FL_NONE, 2'b00, 2'b00, 0, 0, 0, 2'b00);
        mispredict_taken(32'h100);
        chk("perf_mp", EN_ALL, FL_BOTH, 2'b00, 2'b00, 1, 32'h100, 0, 2'b00);
        idle(); load_use_rs1();
        chk("perf_lu0", EN_STALL, FL_IDEX, 2'b00, 2'b00, 0, 0, 0, 2'b00);
        idle();
        chk("perf_lu1", EN_STALL, FL_IDEX, 2'b00, 2'b00, 0, 0, 0, 2'b00);
        @(negedge clk);
`ifdef PIPE_PERF_EN
        perf_exp = {32'd5, 32'd2, 32'd1};
`else
        perf_exp = {32'd0, 32'd0, 32'd0};
`endif
        perf_got = {perf_cyc, perf_stall, perf_flush};
        tests++;
        assert (perf_got === perf_exp) else begin
            fails++;
            $error("FAIL perf: observed %h expected %h", perf_got, perf_exp);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
